// File: rtl/spi_cmd_pkg.sv
// rtl/spi_cmd_pkg.sv - shared opcodes, FSM states and header field layout for spi_cmd_engine
package spi_cmd_pkg;

    typedef enum logic [1:0] {
        OP_NOP    = 2'b00,
        OP_WRITE  = 2'b01,
        OP_READ   = 2'b10,
        OP_STATUS = 2'b11
    } opcode_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_DATA,
        ST_RD_LOAD,
        ST_RD_WAIT_RDY,
        ST_RD_WAIT_REL
    } state_t;

    // Header word: [15:14] opcode, [13:8] LEN, [7:0] start address
    localparam int HDR_OP_LO   = 14;
    localparam int HDR_OP_W    = 2;
    localparam int HDR_LEN_LO  = 8;
    localparam int HDR_LEN_W   = 6;
    localparam int HDR_ADDR_LO = 0;

    localparam logic [7:0] STATUS_MAGIC = 8'hA5;

endpackage

// File: rtl/spi_cmd_regfile.sv
// rtl/spi_cmd_regfile.sv - 1W/2R register file with registered read ports
//   i_clk, i_rst      : clock, async active-high reset (read registers only; storage has no reset)
//   i_we/i_waddr/i_wdata : write port
//   i_raddr_a/o_rdata_a  : read port A, 1-cycle latency
//   i_raddr_b/o_rdata_b  : read port B, 1-cycle latency
// A write and a read of the same address on the same edge return the old data.
module spi_cmd_regfile
    import spi_cmd_pkg::*;
#(
    parameter int DATA_SIZE  = 16,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [DATA_SIZE-1:0]  i_wdata,
    input  logic [ADDR_WIDTH-1:0] i_raddr_a,
    output logic [DATA_SIZE-1:0]  o_rdata_a,
    input  logic [ADDR_WIDTH-1:0] i_raddr_b,
    output logic [DATA_SIZE-1:0]  o_rdata_b
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_SIZE-1:0] r_mem [0:DEPTH-1];
    logic [DATA_SIZE-1:0] r_rdata_a;
    logic [DATA_SIZE-1:0] r_rdata_b;

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rdata_a <= '0;
            r_rdata_b <= '0;
        end else begin
            r_rdata_a <= r_mem[i_raddr_a];
            r_rdata_b <= r_mem[i_raddr_b];
        end
    end

    assign o_rdata_a = r_rdata_a;
    assign o_rdata_b = r_rdata_b;

endmodule

// File: rtl/spi_cmd_engine.sv
// rtl/spi_cmd_engine.sv - SPI command decoder driving a register file (write bursts, read bursts, status)
//   clk, rst            : clock, async active-high reset
//   cs                  : chip select, active low, synchronous to clk
//   rx_valid, rx_data   : received word level handshake from the SPI slave
//   tx_valid, tx_data   : transmit word offered to the SPI slave
//   tx_ready            : pulse from the SPI slave, transmit word consumed
//   acc_addr, acc_rdata : accelerator read port, 1-cycle latency
// Optional feature macro: SPI_CMD_STATUS_EN (STATUS opcode and cs-abort error counter)
module spi_cmd_engine
    import spi_cmd_pkg::*;
#(
    parameter int DATA_SIZE  = 16,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cs,
    input  logic                  rx_valid,
    input  logic [DATA_SIZE-1:0]  rx_data,
    output logic                  tx_valid,
    output logic [DATA_SIZE-1:0]  tx_data,
    input  logic                  tx_ready,
    input  logic [ADDR_WIDTH-1:0] acc_addr,
    output logic [DATA_SIZE-1:0]  acc_rdata
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;

    state_t                  r_state;
    logic                    r_rx_prev;
    logic [HDR_LEN_W-1:0]    r_cnt;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic                    r_rd_pend;
    logic                    r_tx_valid;
    logic [DATA_SIZE-1:0]    r_tx_data;
`ifdef SPI_CMD_STATUS_EN
    logic                    r_status;
    logic [7:0]              r_err_cnt;
`endif

    logic                    w_rx_edge;
    opcode_t                 w_hdr_op;
    logic [HDR_LEN_W-1:0]    w_hdr_len;
    logic [ADDR_WIDTH-1:0]   w_hdr_addr;
    logic                    w_we;
    logic [DATA_SIZE-1:0]    w_rd_data;

    // cs high masks the edge, so an edge arriving with cs rising is dropped
    assign w_rx_edge  = rx_valid & ~r_rx_prev & ~cs;
    assign w_hdr_op   = opcode_t'(rx_data[HDR_OP_LO +: HDR_OP_W]);
    assign w_hdr_len  = rx_data[HDR_LEN_LO +: HDR_LEN_W];
    assign w_hdr_addr = rx_data[HDR_ADDR_LO +: ADDR_WIDTH];
    assign w_we       = (r_state == ST_WR_DATA) && w_rx_edge;

    spi_cmd_regfile #(
        .DATA_SIZE  (DATA_SIZE),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_regfile (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_we      (w_we),
        .i_waddr   (r_addr),
        .i_wdata   (rx_data),
        .i_raddr_a (r_addr),
        .o_rdata_a (w_rd_data),
        .i_raddr_b (acc_addr),
        .o_rdata_b (acc_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_rx_prev  <= 1'b1;   // a high idle rx_valid must not look like a fresh word
            r_cnt      <= '0;
            r_addr     <= '0;
            r_rd_pend  <= 1'b0;
            r_tx_valid <= 1'b0;
            r_tx_data  <= '0;
`ifdef SPI_CMD_STATUS_EN
            r_status   <= 1'b0;
            r_err_cnt  <= '0;
`endif
        end else begin
            r_rx_prev <= rx_valid;
            if (cs) begin
                r_state    <= ST_IDLE;
                r_cnt      <= '0;
                r_addr     <= '0;
                r_rd_pend  <= 1'b0;
                r_tx_valid <= 1'b0;
`ifdef SPI_CMD_STATUS_EN
                r_status   <= 1'b0;
                if (r_state != ST_IDLE && r_err_cnt != 8'hFF) begin
                    r_err_cnt <= r_err_cnt + 8'd1;
                end
`endif
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_rx_edge) begin
                            r_addr <= w_hdr_addr;
                            r_cnt  <= w_hdr_len;
                            case (w_hdr_op)
                                OP_WRITE: if (w_hdr_len != '0) r_state <= ST_WR_DATA;
                                OP_READ:  if (w_hdr_len != '0) r_state <= ST_RD_LOAD;
`ifdef SPI_CMD_STATUS_EN
                                OP_STATUS: begin
                                    // status is always a single word whatever LEN says
                                    r_cnt    <= 6'd1;
                                    r_status <= 1'b1;
                                    r_state  <= ST_RD_LOAD;
                                end
`endif
                                default: ;
                            endcase
                        end
                    end
                    ST_WR_DATA: begin
                        if (w_rx_edge) begin
                            r_addr <= r_addr + ADDR_ONE;
                            r_cnt  <= r_cnt - 6'd1;
                            if (r_cnt == 6'd1) r_state <= ST_IDLE;
                        end
                    end
                    ST_RD_LOAD: begin
                        // first cycle lets the regfile register mem[r_addr]; second captures it
                        if (!r_rd_pend) begin
                            r_rd_pend <= 1'b1;
                        end else begin
                            r_rd_pend  <= 1'b0;
`ifdef SPI_CMD_STATUS_EN
                            r_tx_data  <= r_status ? {STATUS_MAGIC, r_err_cnt} : w_rd_data;
`else
                            r_tx_data  <= w_rd_data;
`endif
                            r_tx_valid <= 1'b1;
                            r_state    <= ST_RD_WAIT_RDY;
                        end
                    end
                    ST_RD_WAIT_RDY: begin
                        if (tx_ready) begin
                            r_tx_valid <= 1'b0;
                            r_addr     <= r_addr + ADDR_ONE;
                            r_cnt      <= r_cnt - 6'd1;
                            r_state    <= ST_RD_WAIT_REL;
                        end
                    end
                    ST_RD_WAIT_REL: begin
                        if (!tx_ready) begin
                            if (r_cnt != '0) begin
                                r_state <= ST_RD_LOAD;
                            end else begin
                                r_state <= ST_IDLE;
`ifdef SPI_CMD_STATUS_EN
                                r_status <= 1'b0;
`endif
                            end
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign tx_valid = r_tx_valid;
    assign tx_data  = r_tx_data;

endmodule

// File: tb/tb_spi_cmd_engine.sv
// tb/tb_spi_cmd_engine.sv - randomized self-checking bench for spi_cmd_engine against a memory-array model
module tb_spi_cmd_engine;

    logic        clk = 1'b0;
    logic        rst;
    logic        cs;
    logic        rx_valid;
    logic [15:0] rx_data;
    logic        tx_valid;
    logic [15:0] tx_data;
    logic        tx_ready;
    logic [7:0]  acc_addr;
    logic [15:0] acc_rdata;

    always #5 clk = ~clk;

    spi_cmd_engine #(.DATA_SIZE(16), .ADDR_WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .cs        (cs),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .tx_ready  (tx_ready),
        .acc_addr  (acc_addr),
        .acc_rdata (acc_rdata)
    );

    int          n_vec = 0;
    int          n_err = 0;
    logic [15:0] mem    [0:255];
    bit          mem_ok [0:255];
    logic [15:0] wbuf   [0:63];
    int          err_m = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [15:0] w);
        rx_data  = w;
        rx_valid = 1'b1;
        tick();
        tick();
        rx_valid = 1'b0;
        repeat ($urandom_range(1, 2)) tick();
    endtask

    task automatic note_abort();
        if (err_m < 255) err_m++;
    endtask

    task automatic acc_check(input logic [7:0] a);
        acc_addr = a;
        tick();
        check("acc_rdata", acc_rdata, mem[a]);
    endtask

    // sends nsend of len data words; nsend < len aborts the burst with cs
    task automatic do_write(input logic [7:0] a, input int len, input int nsend);
        send_word({2'b01, 6'(len), a});
        for (int i = 0; i < nsend; i++) begin
            logic [7:0] wa;
            wa       = a + 8'(i);
            acc_addr = wa;
            rx_data  = wbuf[i];
            rx_valid = 1'b1;
            tick();
            if (mem_ok[wa]) check("wr_same_cycle_old", acc_rdata, mem[wa]);
            mem[wa]    = wbuf[i];
            mem_ok[wa] = 1'b1;
            tick();
            rx_valid = 1'b0;
            repeat ($urandom_range(1, 2)) tick();
        end
        if (nsend < len) begin
            cs = 1'b1;
            tick();
            tick();
            cs = 1'b0;
            tick();
            note_abort();
        end
    endtask

    task automatic wait_tx();
        for (int k = 0; k < 30 && !tx_valid; k++) tick();
        check("tx_valid_rise", tx_valid, 1'b1);
    endtask

    task automatic take_word(input logic [15:0] exp);
        wait_tx();
        check("tx_data", tx_data, exp);
        repeat ($urandom_range(0, 3)) tick();
        check("tx_hold", {tx_valid, tx_data}, {1'b1, exp});
        tx_ready = 1'b1;
        tick();
        check("tx_drop", tx_valid, 1'b0);
        if ($urandom_range(0, 1) == 1) tick();
        tx_ready = 1'b0;
        tick();
    endtask

    task automatic do_read(input logic [7:0] a, input int len);
        send_word({2'b10, 6'(len), a});
        for (int i = 0; i < len; i++) take_word(mem[a + 8'(i)]);
        repeat (6) tick();
        check("rd_idle", tx_valid, 1'b0);
    endtask

    task automatic do_status();
        send_word(16'hC100);
`ifdef SPI_CMD_STATUS_EN
        take_word({8'hA5, 8'(err_m)});
`else
        begin
            bit seen;
            seen = 1'b0;
            repeat (10) begin
                tick();
                if (tx_valid) seen = 1'b1;
            end
            check("status_as_nop", seen, 1'b0);
        end
`endif
    endtask

    initial begin
        rst      = 1'b1;
        cs       = 1'b0;
        rx_valid = 1'b0;
        rx_data  = '0;
        tx_ready = 1'b0;
        acc_addr = '0;
        for (int i = 0; i < 256; i++) mem_ok[i] = 1'b0;
        repeat (3) tick();
        check("rst_tx_valid", tx_valid, 1'b0);
        check("rst_tx_data", tx_data, 16'h0000);
        check("rst_acc_rdata", acc_rdata, 16'h0000);
        rst = 1'b0;
        tick();

        // fill the whole array so every later read has a known value
        for (int b = 0; b < 5; b++) begin
            int len;
            len = (b < 4) ? 63 : 4;
            for (int i = 0; i < len; i++) wbuf[i] = 16'($urandom);
            do_write(8'(b * 63), len, len);
        end

        wbuf[0] = 16'h1111; wbuf[1] = 16'h2222; wbuf[2] = 16'h3333;
        do_write(8'h10, 3, 3);
        acc_check(8'h11);
        check("acc_0x11_literal", acc_rdata, 16'h2222);
        do_read(8'h10, 3);

        // address wrap at the top of the array
        wbuf[0] = 16'hAAAA; wbuf[1] = 16'hBBBB;
        do_write(8'hFF, 2, 2);
        acc_check(8'hFF);
        check("wrap_ff", acc_rdata, 16'hAAAA);
        acc_check(8'h00);
        check("wrap_00", acc_rdata, 16'hBBBB);
        do_read(8'hFF, 2);

        // LEN=0 write stays idle: the next word is a header again
        send_word(16'h4040);
        do_read(8'h40, 1);
        acc_check(8'h40);

        // reset mid-burst with rx_valid held high across deassertion
        wbuf[0] = 16'($urandom);
        send_word({2'b01, 6'd3, 8'h20});
        send_word(wbuf[0]);
        mem[8'h20] = wbuf[0];
        rx_data  = 16'h4105;
        rx_valid = 1'b1;
        rst      = 1'b1;
        #1;
        check("midrst_tx_valid", tx_valid, 1'b0);
        check("midrst_tx_data", tx_data, 16'h0000);
        check("midrst_acc_rdata", acc_rdata, 16'h0000);
        tick();
        rst   = 1'b0;
        err_m = 0;
        repeat (3) tick();
        rx_valid = 1'b0;
        tick();
        send_word(16'h0777);
        acc_check(8'h20);
        acc_check(8'h21);
        acc_check(8'h05);
        do_read(8'h04, 3);

        // cs abort after 2 of 4 words, then a header decoded from idle
        wbuf[0] = 16'h5A01; wbuf[1] = 16'h5A02;
        do_write(8'h80, 4, 2);
        for (int i = 0; i < 4; i++) acc_check(8'h80 + 8'(i));
        do_read(8'h80, 4);
        do_status();

        // rx_valid edge coincident with cs rising is ignored
        cs       = 1'b1;
        rx_data  = 16'h4130;
        rx_valid = 1'b1;
        tick();
        cs = 1'b0;
        tick();
        tick();
        rx_valid = 1'b0;
        tick();
        send_word(16'h0999);
        acc_check(8'h30);

        // cs abort during a read burst
        send_word({2'b10, 6'd3, 8'h50});
        wait_tx();
        cs = 1'b1;
        tick();
        check("rd_abort_drop", tx_valid, 1'b0);
        tick();
        cs = 1'b0;
        tick();
        note_abort();
        do_status();

        // randomized bursts
        for (int it = 0; it < 24; it++) begin
            logic [7:0] a;
            int len, nsend;
            a     = 8'($urandom);
            len   = $urandom_range(1, 8);
            nsend = ($urandom_range(0, 4) == 0) ? $urandom_range(0, len - 1) : len;
            for (int i = 0; i < len; i++) wbuf[i] = 16'($urandom);
            do_write(a, len, nsend);
            acc_check(a + 8'($urandom_range(0, len - 1)));
            do_read(8'($urandom), $urandom_range(1, 8));
        end
        do_status();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/spi_cmd_engine.md
SPI_CMD_ENGINE -- requirements
Module: spi_cmd_engine

Interface
REQ-001 Parameter: DATA_SIZE, 16, word width; only 16 is supported.
REQ-002 Parameter: ADDR_WIDTH, 8, register-file address width; legal range 4..8; depth = 2**ADDR_WIDTH.
REQ-003 Port: clk  in  1  system clock; all logic on rising edge.
REQ-004 Port: rst  in  1  asynchronous, active-high reset.
REQ-005 Port: cs  in  1  SPI chip select, active low, already synchronous to clk.
REQ-006 Port: rx_valid  in  1  level from the SPI slave; high while a complete received word is held.
REQ-007 Port: rx_data  in  DATA_SIZE  received word; stable while rx_valid is high.
REQ-008 Port: tx_valid  out  1  request for the SPI slave to load tx_data.
REQ-009 Port: tx_data  out  DATA_SIZE  word to shift out on MISO.
REQ-010 Port: tx_ready  in  1  SPI slave pulse; the previous transmit word has been consumed.
REQ-011 Port: acc_addr  in  ADDR_WIDTH  accelerator read address.
REQ-012 Port: acc_rdata  out  DATA_SIZE  accelerator read data; 1-cycle latency.

Function
REQ-013 A word is accepted only on a rx_valid rising edge (previous cycle low, current cycle high) while cs=0; the edge is detected with a 1-flop history.
REQ-014 Header word format: [15:14] opcode (00 NOP, 01 WRITE, 10 READ, 11 STATUS); [13:8] LEN; [7:0] start address, truncated to ADDR_WIDTH.
REQ-015 FSM states: IDLE, WR_DATA, RD_LOAD, RD_WAIT_RDY, RD_WAIT_REL.
REQ-016 IDLE: header with LEN=0, NOP, or an illegal opcode -> stay in IDLE; WRITE -> WR_DATA; READ -> RD_LOAD.
REQ-017 WR_DATA: each accepted word is written to mem[addr]; addr increments modulo depth; after LEN words -> IDLE.
REQ-018 RD_LOAD: tx_data <= mem[addr] with 1-cycle read latency, then tx_valid=1 -> RD_WAIT_RDY.
REQ-019 RD_WAIT_RDY: tx_valid and tx_data are held until tx_ready=1; then tx_valid=0 and addr increments -> RD_WAIT_REL.
REQ-020 RD_WAIT_REL: when tx_ready=0, go to RD_LOAD if words remain, else IDLE.
REQ-021 Words received during a READ are discarded.
REQ-022 cs=1 in any state -> IDLE next cycle; tx_valid=0; counters cleared; tx_data is not cleared.
REQ-023 Address wrap is silent: a start of depth-1 with LEN=2 accesses depth-1 and then 0.
REQ-024 A write and an acc read of the same address in the same cycle return the old data.
REQ-025 A rx_valid edge coincident with cs rising is ignored.

Reset
REQ-026 On rst: state=IDLE, tx_valid=0, tx_data=0, acc_rdata=0, edge-detect history=1 (this suppresses a false edge from a high idle rx_valid), counters=0.
REQ-027 Register-file contents are undefined after reset; bench must write before reading.
REQ-028 Reset mid-transfer aborts immediately; no partial write completes after deassertion.

Configuration
REQ-029 Macro SPI_CMD_STATUS_EN.
REQ-030 With SPI_CMD_STATUS_EN defined:
  - STATUS header returns one word {8'hA5, err_cnt[7:0]} via the READ handshake.
  - err_cnt counts cs aborts in WR_DATA or a read state, saturates at 255, and is cleared by rst only.
REQ-031 Without SPI_CMD_STATUS_EN: STATUS is treated as NOP; no err_cnt logic is present.

Structure
REQ-032 Package spi_cmd_pkg holds:
  - opcode enum;
  - FSM state enum;
  - header field bit positions;
  - STATUS_MAGIC=8'hA5.
REQ-033 Sub-module spi_cmd_regfile: 2 read ports, 1 write port, synchronous reads, no reset on storage.

Verification
REQ-034 Write header 0x4310 (WRITE, LEN=3, addr 0x10) then data 0x1111, 0x2222, 0x3333 -> acc_addr=0x11 gives acc_rdata=0x2222.
REQ-035 After REQ-034, read header 0x8310 -> tx_data 0x1111, 0x2222, 0x3333, each held with tx_valid until tx_ready, returning to IDLE.
REQ-036 WRITE LEN=2 at addr 0xFF with data 0xAAAA, 0xBBBB -> mem[0xFF]=0xAAAA, mem[0x00]=0xBBBB.
REQ-037 WRITE LEN=4 with cs raised after 2 data words -> only 2 locations written; the next header is decoded from IDLE.
REQ-038 With SPI_CMD_STATUS_EN: the REQ-037 abort then STATUS header 0xC100 -> tx_data=0xA501; without the macro -> no tx_valid.
REQ-039 rx_valid held high across rst deassertion -> no word accepted; state remains IDLE.
